// File: rtl/ysyx_23060171_gpr_pkg.sv
// Shared types and default widths for the multi-port register file.
// No logic lives here; the FSM state encoding and width defaults are imported by top and scoreboard.
// Optional same-cycle forwarding is selected by YSYX_23060171_GPR_BYPASS_EN (see top).
package ysyx_23060171_gpr_pkg;

  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_DATA_WIDTH = 32;
  localparam int GPR_NR_READ    = 2;
  localparam int GPR_NR_WRITE   = 2;

  // INIT walks the array clearing entries; RUN is normal operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/ysyx_23060171_gpr_sb.sv
// Busy-bit scoreboard: one bit per register, set on allocation, cleared on writeback.
// Latency: updates at posedge, lookups are combinational from stored bits.
// No backpressure; a same-cycle alloc and writeback to one index leaves the bit set.
module ysyx_23060171_gpr_sb
  import ysyx_23060171_gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int NR_READ    = GPR_NR_READ,
  parameter int NR_WRITE   = GPR_NR_WRITE
) (
  input  logic                           clk_i,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic [NR_WRITE-1:0]            wen_i,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr_i,
  input  logic                           alloc_en_i,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr_i,
  input  logic [NR_READ*ADDR_WIDTH-1:0]  raddr_i,
  output logic [NR_READ-1:0]             rbusy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: writebacks clear first, then allocation sets (set wins).
  always_comb begin
    busy_d = busy_q;
    if (en_i) begin
      for (int i = 0; i < NR_WRITE; i++) begin
        if (wen_i[i]) busy_d[waddr_i[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
      if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clr_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Per-read-port lookup of the stored busy bit.
  always_comb begin
    rbusy_o = '0;
    for (int j = 0; j < NR_READ; j++) begin
      rbusy_o[j] = busy_q[raddr_i[j*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

endmodule

// File: rtl/ysyx_23060171_gpr_mp.sv
// Multi-port GPR file with busy scoreboard and post-reset sequential clear (INIT -> RUN).
// Latency: reads combinational; writes/busy changes visible the cycle after the edge
// (same cycle when YSYX_23060171_GPR_BYPASS_EN is defined). No backpressure; ready low during clear.
module ysyx_23060171_gpr_mp
  import ysyx_23060171_gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int NR_READ    = GPR_NR_READ,
  parameter int NR_WRITE   = GPR_NR_WRITE
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           ready,
  input  logic [NR_WRITE-1:0]            wen,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic                           alloc_en,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr,
  input  logic [NR_READ*ADDR_WIDTH-1:0]  raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]  rdata,
  output logic [NR_READ-1:0]             rbusy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  gpr_state_e              state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic                    ready_q;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [NR_READ-1:0]      sb_busy;
  logic                    run;

  assign run   = (state_q == ST_RUN);
  assign ready = ready_q;

  // Clear FSM: ptr starts at 1 (entry 0 is never stored) and stops on all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= ADDR_WIDTH'(1);
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + ADDR_WIDTH'(1);
          if (&ptr_q) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  // Array update: clear walk in INIT; in RUN later ports overwrite earlier ones on conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        regs_q[ptr_q] <= '0;
      end else begin
        for (int i = 0; i < NR_WRITE; i++) begin
          if (wen[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0))
            regs_q[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  ysyx_23060171_gpr_sb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NR_READ    (NR_READ),
    .NR_WRITE   (NR_WRITE)
  ) u_sb (
    .clk_i        (clk),
    .clr_i        (rst),
    .en_i         (run),
    .wen_i        (wen),
    .waddr_i      (waddr),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .raddr_i      (raddr),
    .rbusy_o      (sb_busy)
  );

  // Read muxes: stored value (optionally forwarded), forced to zero for x0 and during INIT.
  always_comb begin : rd_mux
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] val;
    logic                  bsy;
`ifdef YSYX_23060171_GPR_BYPASS_EN
    logic                  hit;
`endif
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NR_READ; j++) begin
      ra  = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
      val = regs_q[ra];
      bsy = sb_busy[j];
`ifdef YSYX_23060171_GPR_BYPASS_EN
      hit = 1'b0;
      for (int i = 0; i < NR_WRITE; i++) begin
        if (wen[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
          val = wdata[i*DATA_WIDTH +: DATA_WIDTH];
          hit = 1'b1;
        end
      end
      if (hit && !(alloc_en && (alloc_addr == ra))) bsy = 1'b0;
`endif
      if (!run || (ra == '0)) begin
        val = '0;
        bsy = 1'b0;
      end
      rdata[j*DATA_WIDTH +: DATA_WIDTH] = val;
      rbusy[j]                          = bsy;
    end
  end

endmodule
